sort_sequencer: RTL

SORT_SEQUENCER -- requirements
Module: sort_sequencer

---
 rtl/sort_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sort_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sort_sequencer
// Purpose  : Collects a batch of DEPTH_P unsigned elements, sorts them in
//            place with an odd-even transposition network (one pass per
//            clock, DEPTH_P passes), then streams the sorted batch out.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i    in   clock, rising edge
//   reset_ni in   synchronous active-low reset
//   valid_i  in   input element valid
//   ready_o  out  block accepts an input element (IDLE/LOAD only)
//   data_i   in   input element, WIDTH_P bits unsigned
//   valid_o  out  data_o holds a sorted element (DRAIN only)
//   ready_i  in   downstream accepts data_o
//   data_o   out  sorted element, zero outside DRAIN
//   busy_o   out  FSM is not IDLE
//   done_o   out  one-cycle pulse after the final element is taken
// ============================================================================
module sort_sequencer #(
    parameter int WIDTH_P      = 8,
    parameter int DEPTH_P      = 8,
    parameter bit DESCENDING_P = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] data_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int c_CNT_W = $clog2(DEPTH_P) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEPTH_P - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SORT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_load_cnt;
    logic [c_CNT_W-1:0]   r_pass_cnt;
    logic [c_CNT_W-1:0]   r_drain_cnt;
    logic                 r_done;
    logic [WIDTH_P-1:0]   r_mem      [DEPTH_P];
    logic [WIDTH_P-1:0]   w_mem_next [DEPTH_P];
    logic [WIDTH_P-1:0]   w_drain_data;
    logic                 w_accepting;
    logic                 w_in_hs;
    logic                 w_out_hs;

    // Ready is a pure function of state (and reset), never of valid_i/ready_i.
    assign w_accepting = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign ready_o     = reset_ni && w_accepting;
    assign valid_o     = reset_ni && (r_state == S_DRAIN);
    assign busy_o      = reset_ni && (r_state != S_IDLE);
    assign done_o      = reset_ni && r_done;
    assign data_o      = valid_o ? w_drain_data : '0;

    assign w_in_hs  = valid_i && ready_o;
    assign w_out_hs = valid_o && ready_i;

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_in_hs) begin
                    w_state_next = (r_load_cnt == c_LAST) ? S_SORT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_in_hs && (r_load_cnt == c_LAST)) begin
                    w_state_next = S_SORT;
                end
            end
            S_SORT: begin
                if (r_pass_cnt == c_LAST) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_hs && (r_drain_cnt == c_LAST)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Storage update: load writes one slot, sort applies one network pass.
    // Even passes pair (0,1),(2,3)...; odd passes pair (1,2),(3,4)... The
    // pairs within a pass are disjoint, so all read the pre-pass contents.
    always_comb begin
        for (int i = 0; i < DEPTH_P; i++) begin
            w_mem_next[i] = r_mem[i];
        end
        if (w_in_hs) begin
            for (int i = 0; i < DEPTH_P; i++) begin
                if (r_load_cnt == c_CNT_W'(i)) begin
                    w_mem_next[i] = data_i;
                end
            end
        end else if (r_state == S_SORT) begin
            for (int k = 0; k < DEPTH_P - 1; k++) begin
                if ((k % 2 == 1) == r_pass_cnt[0]) begin
                    // Strict comparison keeps equal values in place.
                    if (DESCENDING_P ? (r_mem[k] < r_mem[k+1])
                                     : (r_mem[k] > r_mem[k+1])) begin
                        w_mem_next[k]   = r_mem[k+1];
                        w_mem_next[k+1] = r_mem[k];
                    end
                end
            end
        end
    end

    // Output element selection
    always_comb begin
        w_drain_data = '0;
        for (int i = 0; i < DEPTH_P; i++) begin
            if (r_drain_cnt == c_CNT_W'(i)) begin
                w_drain_data = r_mem[i];
            end
        end
    end

    // Element storage carries no reset; contents are only exposed after a
    // complete reload and sort.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH_P; i++) begin
            r_mem[i] <= w_mem_next[i];
        end
    end

    // State and counters
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state     <= S_IDLE;
            r_load_cnt  <= '0;
            r_pass_cnt  <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_out_hs && (r_drain_cnt == c_LAST);
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_in_hs) begin
                        if (r_load_cnt == c_LAST) begin
                            r_load_cnt <= '0;
                            r_pass_cnt <= '0;
                        end else begin
                            r_load_cnt <= r_load_cnt + 1'b1;
                        end
                    end
                end
                S_SORT: begin
                    r_pass_cnt <= r_pass_cnt + 1'b1;
                    if (r_pass_cnt == c_LAST) begin
                        r_drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (w_out_hs) begin
                        r_drain_cnt <= (r_drain_cnt == c_LAST) ? '0
                                                               : r_drain_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
